tx_header_encoder_bluetooth_ble: RTL
====================================

Name: tx_header_encoder_bluetooth_ble

Overview:
- Bluetooth BR header transmit chain; mirror of the header receive chain.
- Takes a 10-bit packet header plus UAP and clock-derived whitening seed.
- Appends the 8-bit HEC, whitens all 18 bits and applies the rate-1/3 repetition code.
- Emits 54 coded bits serially on one clock toward the modulator, with a valid/ready handshake.

Parameters:
REP, 3, repetition factor per whitened bit (receiver decoder expects 3)
HDR_BITS, 10, header payload bits (LT_ADDR, TYPE, FLOW, ARQN, SEQN)
HEC_POLY, 8'hA7, HEC generator low terms (x^8+x^7+x^5+x^2+x+1)

Ports:
clk  in  1  system clock, all logic rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
hdr_in  in  10  header bits, bit0 transmitted first
UAP  in  8  HEC LFSR seed
int_D  in  6  whitening seed (CLK[6:1])
whiten_en  in  1  1 = whiten, 0 = bypass
out_ready  in  1  downstream accepts data_out this cycle
data_out  out  1  coded serial bit
valid_out  out  1  data_out valid
busy  out  1  frame in progress
done  out  1  one-cycle pulse after last bit accepted

Behaviour:
- Reset (reset=0, async): state=IDLE; data_out=0, valid_out=0, busy=0, done=0; all counters and LFSRs cleared.
- States: IDLE -> SEND -> DONE -> IDLE.
- IDLE + start=1:
  - latch hdr_in, UAP, int_D, whiten_en.
  - hec<=UAP; wht<={1'b1,int_D}; bit_idx<=0; rep_cnt<=0.
  - go SEND. busy=1 from next cycle; first valid_out the cycle after start (latency 1).
- SEND:
  - valid_out=1. Raw bit r = hdr[bit_idx] for bit_idx<10, else hec[7-(bit_idx-10)], i.e. HEC MSB first.
  - data_out = r ^ (whiten_en & wht[6]). Output is registered; data_out is stable while valid_out & !out_ready.
  - Transfer occurs when valid_out & out_ready. On a transfer:
    - rep_cnt increments.
    - When rep_cnt==REP-1: rep_cnt<=0; bit_idx++; advance wht; if bit_idx<10, advance hec with r.
- HEC step: fb=d^hec[7]; hec<={hec[6:0],1'b0} ^ (fb ? HEC_POLY : 0).
  - hec is frozen after bit 9; bits 10..17 read the frozen register.
- Whitening step (x^7+x^4+1):
  - next = {wht[5:0],wht[6]}, with next[4] = wht[3]^wht[6].
  - wht advances even when whiten_en=0; the output is simply unmasked.
- Frame length:
  - After the transfer with bit_idx==17 and rep_cnt==REP-1, go DONE.
  - Total 54 transfers; with out_ready held at 1, exactly 54 consecutive valid cycles.
- DONE: valid_out=0, busy=0, done=1 for one cycle; next state IDLE. A start in DONE is ignored.
- start during SEND/DONE: ignored; latched inputs are not disturbed.
- Input changes after the start cycle have no effect on the current frame.
- reset asserted mid-frame: immediate return to IDLE; partial frame abandoned; no done pulse.
- out_ready low indefinitely: hold state, valid_out stays 1, no counter or LFSR movement.

Test Plan:
- Zero frame: hdr_in=0, UAP=0, whiten_en=0, out_ready=1.
  - Response: 54 valid cycles all data_out=0; done pulses on cycle 56 counted from start; busy low after.
- HEC check: hdr_in=10'h001, UAP=0, whiten_en=0.
  - Response: triplets 111 then 27 zeros, then HEC 8'h16 MSB first: 000 000 000 111 000 111 111 000.
- Whitening: hdr_in=0, UAP=0, int_D=0, whiten_en=1.
  - Response: first 12 bits 111 000 000 111 (whitening sequence 1,0,0,1).
- Backpressure: out_ready toggled 1,0,0,1 pattern through a frame.
  - Response: same 54-bit sequence as with out_ready=1.
  - data_out is held while stalled; done pulses only after the 54th accepted bit.
- Robustness: reset pulled low at transfer 20, then start with new hdr_in.
  - Response: outputs zero during reset; new frame starts cleanly; no done pulse for the aborted frame.
  - Also: start pulsed mid-frame is ignored.
- Loopback: random hdr_in, UAP, int_D (≥200 frames) passed through a QPSK mapper into the receive chain with matching UAP and n_bits=18.
  - Response: header_error_flag=0 and recovered header equals hdr_in.

Source files
------------

// File: rtl/tx_header_encoder_bluetooth_ble.sv
// -----------------------------------------------------------------------------
// tx_header_encoder_bluetooth_ble
//
// Bluetooth BR packet-header transmit chain. A one-cycle start in IDLE latches
// a 10-bit header, the UAP (HEC seed), the clock-derived whitening seed and the
// whitening enable. The block then streams 54 coded bits toward the modulator:
// 10 header bits followed by the 8-bit HEC (MSB first), every bit whitened and
// repeated REP times.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : one-cycle frame request, honoured only in IDLE
//   hdr_in     : header bits, bit 0 sent first
//   UAP        : HEC LFSR seed
//   int_D      : whitening seed (CLK[6:1])
//   whiten_en  : 1 = whiten, 0 = bypass (LFSR still advances)
//   out_ready  : downstream accepts data_out this cycle
//   data_out   : coded serial bit (registered, held while stalled)
//   valid_out  : data_out valid
//   busy       : frame in progress
//   done       : one-cycle pulse after the last bit is accepted
// -----------------------------------------------------------------------------
module tx_header_encoder_bluetooth_ble #(
    parameter int         REP      = 3,
    parameter int         HDR_BITS = 10,
    parameter logic [7:0] HEC_POLY = 8'hA7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [HDR_BITS-1:0] hdr_in,
    input  logic [7:0]          UAP,
    input  logic [5:0]          int_D,
    input  logic                whiten_en,
    input  logic                out_ready,
    output logic                data_out,
    output logic                valid_out,
    output logic                busy,
    output logic                done
);

    localparam int IDX_W = $clog2(HDR_BITS + 8);
    localparam int HI_W  = $clog2(HDR_BITS);
    localparam int REP_W = (REP > 1) ? $clog2(REP) : 1;

    localparam logic [IDX_W-1:0] HDR_END  = IDX_W'(HDR_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_BITS + 7);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One HEC LFSR step: feedback is the data bit xor the register MSB.
    function automatic logic [7:0] hec_step(input logic [7:0] hec, input logic d);
        logic fb;
        fb       = d ^ hec[7];
        hec_step = {hec[6:0], 1'b0} ^ (fb ? HEC_POLY : 8'h00);
    endfunction

    // One whitening LFSR step for x^7 + x^4 + 1 (Galois form).
    function automatic logic [6:0] wht_step(input logic [6:0] w);
        wht_step    = {w[5:0], w[6]};
        wht_step[4] = w[3] ^ w[6];
    endfunction

    // Unwhitened bit for a frame position: header LSB first, then HEC MSB first.
    function automatic logic raw_bit(input logic [HDR_BITS-1:0] hdr,
                                     input logic [7:0] hec,
                                     input logic [IDX_W-1:0] idx);
        logic [2:0] off;
        off = 3'(idx - HDR_END);
        if (idx < HDR_END) begin
            raw_bit = hdr[idx[HI_W-1:0]];
        end else begin
            // 7 - off on a 3-bit value is simply its complement
            raw_bit = hec[~off];
        end
    endfunction

    logic [1:0]          state_r, state_s;
    logic [HDR_BITS-1:0] hdr_r, hdr_s;
    logic [7:0]          hec_r, hec_s;
    logic [6:0]          wht_r, wht_s;
    logic                wen_r, wen_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic [REP_W-1:0]    rep_r, rep_s;
    logic                raw_s;
    logic                data_s, valid_s, done_s;
    logic                data_out_r, valid_out_r, busy_r, done_r;

    // Next-state logic: frame sequencing, HEC and whitening advance per bit.
    always_comb begin
        state_s = state_r;
        hdr_s   = hdr_r;
        hec_s   = hec_r;
        wht_s   = wht_r;
        wen_s   = wen_r;
        idx_s   = idx_r;
        rep_s   = rep_r;
        done_s  = 1'b0;
        raw_s   = raw_bit(hdr_r, hec_r, idx_r);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    hdr_s   = hdr_in;
                    hec_s   = UAP;
                    wht_s   = {1'b1, int_D};
                    wen_s   = whiten_en;
                    idx_s   = {IDX_W{1'b0}};
                    rep_s   = {REP_W{1'b0}};
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (rep_r == REP_LAST) begin
                        rep_s = {REP_W{1'b0}};
                        idx_s = idx_r + IDX_ONE;
                        wht_s = wht_step(wht_r);
                        // HEC only absorbs header bits; it is frozen while being sent
                        if (idx_r < HDR_END) begin
                            hec_s = hec_step(hec_r, raw_s);
                        end else begin
                            hec_s = hec_r;
                        end
                        if (idx_r == LAST_IDX) begin
                            state_s = ST_DONE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_SEND;
                        end
                    end else begin
                        rep_s = rep_r + REP_ONE;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output bit is derived from the next state so that it is registered.
    always_comb begin
        valid_s = (state_s == ST_SEND);
        if (valid_s) begin
            data_s = raw_bit(hdr_s, hec_s, idx_s) ^ (wen_s & wht_s[6]);
        end else begin
            data_s = 1'b0;
        end
    end

    // State, latched frame context and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            hdr_r       <= {HDR_BITS{1'b0}};
            hec_r       <= 8'h00;
            wht_r       <= 7'h00;
            wen_r       <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
            rep_r       <= {REP_W{1'b0}};
            data_out_r  <= 1'b0;
            valid_out_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            hdr_r       <= hdr_s;
            hec_r       <= hec_s;
            wht_r       <= wht_s;
            wen_r       <= wen_s;
            idx_r       <= idx_s;
            rep_r       <= rep_s;
            data_out_r  <= data_s;
            valid_out_r <= valid_s;
            busy_r      <= valid_s;
            done_r      <= done_s;
        end
    end

    assign data_out  = data_out_r;
    assign valid_out = valid_out_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
